// File: rtl/pbus_pkg.sv
// Shared types and constants for the P-port bus initiator: FSM states,
// RV32I load/store funct3 encodings and the byte-enable patterns driven on PRW.
package pbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B  = 4'b0001;
    localparam logic [3:0] BE_H  = 4'b0011;
    localparam logic [3:0] BE_W  = 4'b1111;
    localparam logic [3:0] BE_RD = 4'b0000;

    // Unknown store widths fall back to a full-word write.
    function automatic logic [3:0] store_be(input logic [2:0] funct3);
        case (funct3)
            F3_B:    store_be = BE_B;
            F3_H:    store_be = BE_H;
            default: store_be = BE_W;
        endcase
    endfunction

endpackage

// File: rtl/pbus_load_ext.sv
// Combinational load formatter: selects byte/half/word from lane 0 of the
// returned data and sign- or zero-extends it according to funct3.
import pbus_pkg::*;

module pbus_load_ext (
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    // NOTE: assign a default before the case so every path drives data and no latch is inferred.
    always_comb begin
        data = raw;
        case (funct3)
            F3_B:    data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    data = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   data = {24'd0, raw[7:0]};
            F3_HU:   data = {16'd0, raw[15:0]};
            F3_W:    data = raw;
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/pbus_initiator.sv
// MEM-stage initiator for the data cache P-port: one load/store at a time,
// IDLE -> REQ -> WAIT -> IDLE. Define PBUS_TIMEOUT_EN to bound WAIT with an abort.
import pbus_pkg::*;

module pbus_initiator #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              PStrobe,
    output logic [ADDR_W-1:0] PAddress,
    output logic [3:0]        PRW,
    output logic [DATA_W-1:0] pdata_out,
    output logic              pdata_oe,
    input  logic [DATA_W-1:0] pdata_in,
    input  logic              PReady
);

    state_e            state_q, state_d;
    logic              load_q;
    logic [2:0]        funct3_q;
    logic              accept, complete, abort;
    logic [DATA_W-1:0] ext_data;

`ifdef PBUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = REQ;
                    accept  = 1'b1;
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                // A PReady coinciding with the timeout limit still completes normally.
                if (PReady) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
`ifdef PBUS_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            load_q     <= 1'b0;
            funct3_q   <= 3'd0;
            PStrobe    <= 1'b0;
            PAddress   <= '0;
            PRW        <= BE_RD;
            pdata_out  <= '0;
            pdata_oe   <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state_q    <= state_d;
            PStrobe    <= accept;
            resp_valid <= complete | abort;
            if (accept) begin
                load_q    <= req_load;
                funct3_q  <= req_funct3;
                PAddress  <= req_addr;
                pdata_out <= req_wdata;
                PRW       <= req_load ? BE_RD : store_be(req_funct3);
                pdata_oe  <= ~req_load;
            end
            // Address and write data stay on the bus after completion; only the enables drop.
            if (complete || abort) begin
                PRW      <= BE_RD;
                pdata_oe <= 1'b0;
            end
            if (complete)
                resp_rdata <= load_q ? ext_data : '0;
            else if (abort)
                resp_rdata <= '0;
        end
    end

`ifdef PBUS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt  <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state_q == REQ)
                tmo_cnt <= '0;
            else if (state_q == WAIT && !PReady)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (complete || abort)
                resp_err <= abort;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

    assign stall = (state_q != IDLE);

    pbus_load_ext u_load_ext (
        .funct3 (funct3_q),
        .raw    (pdata_in),
        .data   (ext_data)
    );

endmodule

// File: doc/pbus_initiator.md
Name: pbus_initiator

Overview:
- Processor-side bus initiator for the data cache's P-port.
- Sits in the CPU MEM stage.
- Accepts one load/store command at a time from the pipeline and issues a PStrobe/PAddress/PRW/PData transaction to the cache.
- Holds the pipeline stalled until PReady, then returns sign/zero-extended load data or store completion.

Parameters:
- ADDR_W, 16, width of PAddress.
- DATA_W, 32, width of data bus (fixed 32; byte lanes = DATA_W/8).
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (used only with PBUS_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  pipeline command valid; sampled only in IDLE
- req_load  in  1  1=load, 0=store
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data (unshifted, lane 0 = byte at req_addr)
- stall  out  1  high while a transaction is in flight
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  formatted load data (0 for stores)
- resp_err  out  1  timeout abort flag, qualified by resp_valid
- PStrobe  out  1  transaction start pulse
- PAddress  out  ADDR_W  held address
- PRW  out  4  byte write enables; 0000 = read
- pdata_out  out  DATA_W  write data; top level drives PData when pdata_oe=1
- pdata_oe  out  1  PData driver enable
- pdata_in  in  DATA_W  PData as seen on the bus (read data)
- PReady  in  1  cache completion pulse

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, PStrobe=0, PAddress=0, PRW=0, pdata_out=0, pdata_oe=0, stall=0, resp_valid=0, resp_rdata=0, resp_err=0, timeout counter=0.
- Reset mid-transaction: abandon the transaction, emit no response; the cache is reset by the same event.
- FSM is IDLE -> REQ -> WAIT -> IDLE.
- IDLE:
  - If req_valid, latch addr, data, funct3 and load, then go to REQ.
  - PRW = 0000 for a load. For a store, PRW = SB 0001, SH 0011, SW 1111; other store funct3 values are treated as SW.
  - pdata_oe = 1 for a store, 0 for a load.
- REQ (exactly one cycle): PStrobe=1, then go to WAIT. PReady is ignored in REQ.
- WAIT:
  - PStrobe=0; PAddress, PRW, pdata_out and pdata_oe are held stable.
  - On PReady=1: go to IDLE and register the response, so resp_valid=1 in the following cycle.
  - pdata_oe and PRW clear on the same edge that leaves WAIT.
- stall = (state != IDLE). It is registered, so it rises the cycle after req_valid is accepted.
- Latency: req accepted at edge N; PStrobe high in cycle N+1; with earliest PReady in cycle N+2, resp_valid is high in cycle N+3.
- Back-to-back: a new req_valid is accepted in the same cycle resp_valid=1, giving throughput of 1 transaction per 3 cycles minimum.
- Load formatting (no lane shift; byte 0 = byte at address), from pdata_in sampled when PReady=1:
  - LB: sext([7:0]).
  - LH: sext([15:0]).
  - LW: all 32 bits.
  - LBU / LHU: zero-extend [7:0] / [15:0].
  - funct3 011, 110, 111: treated as LW.
- Stores: resp_rdata=0.
- resp_rdata holds its value until the next response; resp_err is 0 without timeout.
- req_valid seen while stall=1 is ignored; the pipeline must hold its request.

Optional Feature:
- PBUS_TIMEOUT_EN defined:
  - A counter clears on entering WAIT and increments each WAIT cycle without PReady.
  - When it reaches TIMEOUT_CYCLES, go to IDLE and emit resp_valid=1, resp_err=1, resp_rdata=0.
  - PStrobe is not reissued.
  - If PReady arrives in the same cycle as the limit, PReady wins (normal response).
- Undefined: no counter logic; WAIT is unbounded; resp_err is tied to 0.

Decomposition:
- Package pbus_pkg:
  - state enum (IDLE, REQ, WAIT).
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - byte-enable constants BE_B=0001, BE_H=0011, BE_W=1111, BE_RD=0000.
- One sub-module, pbus_load_ext: combinational funct3-driven load extension, instantiated once.

Test Plan:
- LW @0x9000, cache returns 0x12345678 with PReady 1 cycle after PStrobe -> PRW=0000, pdata_oe=0, resp_valid in cycle N+3, resp_rdata=0x12345678, stall high exactly 2 cycles.
- SB @0x9004 wdata 0xAABBCCDD, PReady after 5 WAIT cycles -> PRW=0001, pdata_oe=1 and PAddress stable until PReady, PStrobe high exactly 1 cycle, resp_rdata=0.
- LB / LBU / LH / LHU with pdata_in=0x0000_80F0 -> 0xFFFFFFF0 / 0x000000F0 / 0xFFFF80F0 / 0x000080F0.
- Back-to-back SW then LW, req_valid presented in the resp_valid cycle -> second PStrobe 1 cycle after first resp_valid; second request not dropped.
- rst=0 asserted in WAIT -> next cycle all outputs 0, state IDLE, no resp_valid; a subsequent LW completes normally.
- With PBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, PReady never asserted -> resp_valid=1, resp_err=1, resp_rdata=0 after 4 WAIT cycles. Without the macro, stall stays high indefinitely and resp_err stays 0.
